rf_write_arbiter: RTL

//  Drives the register file's write port (RegWEn/AddrD/DataD) from two writeback sources:

---
 rtl/rf_pkg.sv | 24 ++
 rtl/rf_wb_fifo.sv | 56 +++++
 rtl/rf_write_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file writeback types: datapath widths, writeback source tags
// and the (rd, data) entry carried by both writeback sources.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wbSrc_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wbEntry_t;

  // x0 is hardwired: entries targeting it are consumed but never written.
  function automatic logic writesReg(input logic [REG_AW-1:0] rd);
    return rd != '0;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering load returns until the write port is free.
// Pushes while full and pops while empty are ignored.
module rf_wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     push,
  input  wbEntry_t pushData,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output wbEntry_t head
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];

  wbEntry_t      mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          doPush;
  logic          doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign full   = count == CNT_FULL;
  assign empty  = count == '0;
  assign head   = mem[rdPtr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port arbiter: ALU results win by default, buffered load
// returns fill idle cycles and are forced through after STARVE_MAX lost cycles.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              AluWEn,
  input  logic [REG_AW-1:0] AluRd,
  input  logic [XLEN-1:0]   AluData,
  output logic              AluStall,
  input  logic              LsuVld,
  input  logic [REG_AW-1:0] LsuRd,
  input  logic [XLEN-1:0]   LsuData,
  output logic              LsuRdy,
  input  logic              IssueVld,
  input  logic [REG_AW-1:0] IssueRd,
  input  logic [REG_AW-1:0] AddrA,
  input  logic [REG_AW-1:0] AddrB,
  output logic              StallA,
  output logic              StallB,
  output logic              RegWEn,
  output logic [REG_AW-1:0] AddrD,
  output logic [XLEN-1:0]   DataD
);

  localparam int            CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);
  localparam logic [CW-1:0] CNT_ONE = 1;

  // Handshakes: a load return transfers on a rising edge where LsuVld && LsuRdy,
  // and its source holds rd/data while LsuRdy is low. An ALU request transfers on
  // an edge where AluWEn && !AluStall; while stalled the source holds AluRd/AluData.
  wbEntry_t          lsuIn;
  wbEntry_t          fifoHead;
  wbEntry_t          selEntry;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              fifoPush;
  logic              fifoPop;
  logic              takeAlu;
  logic              forceLsu;
  logic [CW-1:0]     starveCnt;
  logic [CW-1:0]     starveCntNxt;
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pendNxt;
  wbSrc_t            srcQ;

  assign lsuIn    = '{rd: LsuRd, data: LsuData};
  assign LsuRdy   = !RST && !fifoFull;
  assign fifoPush = LsuVld && LsuRdy;

  rf_wb_fifo #(.DEPTH(DEPTH)) uFifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (fifoPush),
    .pushData (lsuIn),
    .pop      (fifoPop),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .head     (fifoHead)
  );

  always_comb begin
    forceLsu     = (starveCnt == CNT_MAX) && !fifoEmpty;
    fifoPop      = !fifoEmpty && (forceLsu || !AluWEn);
    takeAlu      = AluWEn && !forceLsu;
    AluStall     = forceLsu && AluWEn;
    selEntry     = fifoPop ? fifoHead : '{rd: AluRd, data: AluData};
    starveCntNxt = starveCnt;
    if (fifoPop || fifoEmpty) begin
      starveCntNxt = '0;
    end else if (takeAlu && starveCnt != CNT_MAX) begin
      starveCntNxt = starveCnt + CNT_ONE;
    end
  end

  // Set is applied after clear so a re-issue in the commit cycle stays pending.
  always_comb begin
    pendNxt = pend;
    if (RegWEn && srcQ == SRC_LSU) pendNxt[AddrD] = 1'b0;
    if (IssueVld && writesReg(IssueRd)) pendNxt[IssueRd] = 1'b1;
  end

  assign StallA = writesReg(AddrA) && pend[AddrA];
  assign StallB = writesReg(AddrB) && pend[AddrB];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RegWEn    <= 1'b0;
      AddrD     <= '0;
      DataD     <= '0;
      srcQ      <= SRC_ALU;
      starveCnt <= '0;
      pend      <= '0;
    end else begin
      starveCnt <= starveCntNxt;
      pend      <= pendNxt;
      srcQ      <= fifoPop ? SRC_LSU : SRC_ALU;
      if (fifoPop || takeAlu) begin
        RegWEn <= writesReg(selEntry.rd);
        if (writesReg(selEntry.rd)) begin
          AddrD <= selEntry.rd;
          DataD <= selEntry.data;
        end
      end else begin
        RegWEn <= 1'b0;
      end
    end
  end

endmodule
